// File: rtl/seg7_disp_ctrl.sv
// Front-panel controller: debounced up/down buttons step a 4-bit register select, and a
// 16-bit debug value is scanned onto a 4-digit active-low 7-segment display.
module seg7_disp_ctrl #(
  parameter int unsigned REFRESH_CNT  = 100000,
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic [15:0] out_val,
  output logic [3:0]  disp,
  output logic [3:0]  disp_led,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam logic [CNT_W-1:0] RefreshLast  = CNT_W'(REFRESH_CNT - 1);
  localparam logic [CNT_W-1:0] DebounceLast = CNT_W'(DEBOUNCE_CNT - 1);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [3:0]       disp_q, disp_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign btn_raw = {btn_dn, btn_up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      // Any return to the stable level leaves the counter cleared, restarting the count.
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DebounceLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
    step_d = stable_d & ~stable_q;

    disp_d = disp_q;
    unique case (step_q)
      2'b01:   disp_d = disp_q + 4'd1;
      2'b10:   disp_d = disp_q - 4'd1;
      default: disp_d = disp_q;
    endcase
  end

  always_comb begin
    tick    = (rcnt_q == RefreshLast);
    rcnt_d  = tick ? '0 : rcnt_q + 1'b1;
    digit_d = digit_q;
    snap_d  = snap_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (tick) begin
      digit_d = digit_q + 2'd1;
      // Snapshot only at frame start so all four digits come from one value.
      if (digit_q == 2'd3) snap_d = out_val;
      an_d  = ~(4'b0001 << digit_d);
      seg_d = hex2seg(snap_d[{digit_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      step_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      disp_q      <= '0;
      rcnt_q      <= '0;
      digit_q     <= 2'd3;
      snap_q      <= '0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      step_q      <= step_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      disp_q      <= disp_d;
      rcnt_q      <= rcnt_d;
      digit_q     <= digit_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign disp     = disp_q;
  assign disp_led = disp_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule
